// File: rtl/d_ff_pkg.sv
// -----------------------------------------------------------------------------
// d_ff_pkg
// Shared datapath constants for wrappers built on the d_ff storage cell.
// The d_ff cell itself does not import this package; only wrappers do, so the
// leaf cell stays reusable on its own.
//   WORD_W : datapath word width used as the default register width.
// -----------------------------------------------------------------------------
package d_ff_pkg;

  localparam int WORD_W = 64;

endpackage : d_ff_pkg

// File: rtl/d_ff_slice.sv
// -----------------------------------------------------------------------------
// d_ff_slice
// Bit-sliced register: one WIDTH=1 d_ff instance per bit. Must behave exactly
// like a single d_ff with the same WIDTH and RESET_VALUE.
//
// Parameters
//   WIDTH       : register width, defaults to the datapath word width
//   RESET_VALUE : per-bit reset value, bit i goes to instance i
// Ports
//   clk, reset, d, q : as for d_ff
// -----------------------------------------------------------------------------
module d_ff_slice
  import d_ff_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    d_ff #(
      .WIDTH       (1),
      .RESET_VALUE (RESET_VALUE[gi])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .d     (d[gi]),
      .q     (q[gi])
    );
  end

endmodule : d_ff_slice

// File: rtl/d_ff.sv
// -----------------------------------------------------------------------------
// d_ff
// Positive-edge D flip-flop with synchronous active-low reset. This is the
// leaf storage cell of the datapath; wider registers replicate it per bit or
// set WIDTH directly, and both forms behave identically.
//
// Parameters
//   WIDTH       : number of independent bits stored (legal range 1..64)
//   RESET_VALUE : value loaded into q when reset = 0 is sampled
// Ports
//   clk   : in  clock, all state changes on its rising edge
//   reset : in  synchronous active-low reset, sampled at the rising edge
//   d     : in  data to capture
//   q     : out registered data, no combinational path from d or reset
// -----------------------------------------------------------------------------
module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next-state value: plain pass-through of d, no masking or conversion.
  always_comb begin
    q_d = d;
  end

  // Storage flop; reset is sampled only at the edge so it maps to a
  // synchronous clear/set rather than an asynchronous one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifndef SYNTHESIS
  // Reject illegal widths at elaboration.
  if (WIDTH < 1) begin : g_width_low
    $error("d_ff: WIDTH must be at least 1");
  end
  if (WIDTH > 64) begin : g_width_high
    $error("d_ff: WIDTH must not exceed 64");
  end

  // A sampled reset loads RESET_VALUE regardless of d or the previous q.
  a_reset_loads : assert property (@(posedge clk) !reset |=> (q == RESET_VALUE));

  // Out of reset, q is exactly the d sampled at the previous edge.
  a_capture : assert property (@(posedge clk) reset |=> (q === $past(d)));
`endif

endmodule : d_ff

// File: tb/tb_d_ff.sv
`timescale 1ns/10ps
// -----------------------------------------------------------------------------
// tb_d_ff
// Directed, table-driven bench for d_ff: a 1-bit cell, a 64-bit cell, a
// 64-bit bit-sliced register and an 8-bit cell with a nonzero reset value.
// -----------------------------------------------------------------------------
module tb_d_ff;

  logic        clk;
  logic        reset;
  logic        d1;
  logic        q1;
  logic [63:0] dw;
  logic [63:0] qw;
  logic [63:0] qs;
  logic [7:0]  d8;
  logic [7:0]  q8;

  int n_checks;
  int n_errors;

  d_ff u_dut1 (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  d_ff #(.WIDTH(64)) u_dutw (
    .clk   (clk),
    .reset (reset),
    .d     (dw),
    .q     (qw)
  );

  d_ff_slice #(.WIDTH(64)) u_duts (
    .clk   (clk),
    .reset (reset),
    .d     (dw),
    .q     (qs)
  );

  d_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then let one rising edge pass.
  task automatic step(input logic rst, input logic dv);
    @(negedge clk);
    reset = rst;
    d1    = dv;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic  rst;
    logic  d;
    logic  exp_q;
    string name;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [63:0] prev_dw;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    d1       = 1'b0;
    dw       = 64'h0;
    d8       = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 1'b0, "powerup_reset_ignores_d"};
    vecs[1] = '{1'b1, 1'b1, 1'b1, "capture_1"};
    vecs[2] = '{1'b1, 1'b0, 1'b0, "capture_0"};
    vecs[3] = '{1'b1, 1'b1, 1'b1, "capture_1b"};
    vecs[4] = '{1'b1, 1'b1, 1'b1, "capture_1c"};
    vecs[5] = '{1'b0, 1'b1, 1'b0, "midstream_reset"};
    vecs[6] = '{1'b0, 1'b0, 1'b0, "reset_held_d0"};
    vecs[7] = '{1'b1, 1'b0, 1'b0, "capture_after_reset_0"};
    vecs[8] = '{1'b1, 1'b1, 1'b1, "capture_after_reset_1"};
    vecs[9] = '{1'b1, 1'b1, 1'b1, "capture_hold_1"};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].d);
      chk(vecs[i].name, {63'h0, q1}, {63'h0, vecs[i].exp_q});
    end

    // Hold between edges: q=1 now; wiggle d and reset mid-cycle, leaving
    // reset=1 and d=0 just before the edge.
    @(negedge clk);
    d1 = 1'b0;
    #1 d1 = 1'b1;
    #1 chk("hold_mid_d_toggle", {63'h0, q1}, 64'h1);
    d1 = 1'b0;
    reset = 1'b0;
    #1 chk("hold_mid_reset_glitch", {63'h0, q1}, 64'h1);
    reset = 1'b1;
    d1 = 1'b1;
    #1 d1 = 1'b0;
    #0.5 chk("hold_before_edge", {63'h0, q1}, 64'h1);
    @(posedge clk);
    #1 chk("hold_after_edge", {63'h0, q1}, 64'h0);

    // Reset mid-stream with release: q=1, reset sampled low with d=1.
    step(1'b1, 1'b1);
    chk("pre_reset_q1", {63'h0, q1}, 64'h1);
    step(1'b0, 1'b1);
    chk("reset_with_d1", {63'h0, q1}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    d1    = 1'b1;
    #2 chk("release_no_change_before_edge", {63'h0, q1}, 64'h0);
    @(posedge clk);
    #1 chk("release_capture_next_edge", {63'h0, q1}, 64'h1);

    // Nonzero RESET_VALUE on the 8-bit cell.
    @(negedge clk);
    reset = 1'b0;
    d8    = 8'h3C;
    @(posedge clk);
    #1 chk("rv8_reset", {56'h0, q8}, 64'h0000_0000_0000_00A5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("rv8_capture", {56'h0, q8}, 64'h0000_0000_0000_003C);

    // Wide random: one reset edge, then 50 random cycles on both forms.
    @(negedge clk);
    reset = 1'b0;
    dw    = {$urandom, $urandom};
    @(posedge clk);
    #1;
    chk("wide_reset_w", qw, 64'h0);
    chk("wide_reset_s", qs, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      dw      = {$urandom, $urandom};
      prev_dw = dw;
      @(posedge clk);
      #1;
      chk($sformatf("wide_w_c%0d", c), qw, prev_dw);
      chk($sformatf("wide_s_c%0d", c), qs, prev_dw);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_d_ff
